// File: rtl/bcd_binary_if.sv
// Handshake/data bundle between operand entry logic and the BCD-to-binary converter.
interface bcd_binary_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned OUT_W  = 16
);
  logic                  valid;
  logic [4*DIGITS-1:0]   BCD_code;
  logic                  sign;
  logic                  busy;
  logic                  binary_ready;
  logic [OUT_W-1:0]      binary;
  logic                  error;

  modport master (
    output valid, BCD_code, sign,
    input  busy, binary_ready, binary, error
  );

  modport slave (
    input  valid, BCD_code, sign,
    output busy, binary_ready, binary, error
  );
endinterface

// File: rtl/bcd_binary.sv
// Iterative reverse double-dabble: packed BCD + sign -> two's-complement binary.
// Define BCD_BINARY_SIGN_EN to apply the sign input; otherwise results are unsigned magnitudes.
module bcd_binary #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned OUT_W  = 16
) (
  input logic          clk,
  input logic          reset,
  bcd_binary_if.slave  bus
);

  localparam int unsigned BIN_W = $clog2(10 ** DIGITS);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_q;
  logic               err_q;
  logic               busy_q;
  logic               ready_q;
  logic [OUT_W-1:0]   binary_q;
  logic               error_q;

  logic [BCD_W-1:0]       bcd_nxt;
  logic [BIN_W-1:0]       acc_nxt;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic                   bad_digit;
  logic [OUT_W-1:0]       mag;
  logic [OUT_W-1:0]       result;

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.BCD_code[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then pull any digit >= 8 back by 3.
  always_comb begin
    shifted = {bcd_q, acc_q} >> 1;
    bcd_nxt = shifted[BIN_W +: BCD_W];
    acc_nxt = shifted[BIN_W-1:0];
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_nxt[4*i +: 4] >= 4'd8) bcd_nxt[4*i +: 4] = bcd_nxt[4*i +: 4] - 4'd3;
    end
  end

  assign mag = {{(OUT_W - BIN_W){1'b0}}, acc_q};

`ifdef BCD_BINARY_SIGN_EN
  // Negating zero yields zero, so no negative-zero special case is needed.
  assign result = sign_q ? -mag : mag;
`else
  logic unused_sign;
  assign unused_sign = sign_q;
  assign result      = mag;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      bcd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      binary_q <= '0;
      error_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (bus.valid) begin
            bcd_q   <= bus.BCD_code;
            sign_q  <= bus.sign;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            err_q   <= bad_digit;
            state_q <= bad_digit ? StDone : StShift;
          end
        end
        StShift: begin
          bcd_q <= bcd_nxt;
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= StDone;
        end
        StDone: begin
          ready_q  <= 1'b1;
          error_q  <= err_q;
          binary_q <= err_q ? '0 : result;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.binary_ready = ready_q;
  assign bus.binary       = binary_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_bcd_binary.sv
// Scoreboard bench for bcd_binary: driver pushes expected results, negedge monitor pops/compares.
`timescale 1ns/1ps
module tb_bcd_binary;

`ifdef BCD_BINARY_SIGN_EN
  localparam bit SignEn = 1'b1;
`else
  localparam bit SignEn = 1'b0;
`endif

  typedef struct {
    logic [15:0] binary;
    logic        error;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t last;

  bcd_binary_if #(.DIGITS(4), .OUT_W(16)) bus ();

  bcd_binary #(.DIGITS(4), .OUT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset && bus.binary_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("binary", 32'(bus.binary), 32'(e.binary));
        check("error", 32'(bus.error), 32'(e.error));
        check("latency_cycle", 32'(cyc), 32'(e.cyc));
        check("busy_in_ready", 32'(bus.busy), 32'd1);
        last = e;
      end
    end
  end

  task automatic push_exp(input logic s, input logic [15:0] exp_s, input logic [15:0] exp_u,
                          input logic err, input int lat);
    exp_t e;
    e.binary = err ? 16'h0000 : ((SignEn && s) ? exp_s : exp_u);
    e.error  = err;
    e.cyc    = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check("ready_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
    check("hold_binary", 32'(bus.binary), 32'(last.binary));
    check("hold_error", 32'(bus.error), 32'(last.error));
    check("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  task automatic send(input logic [15:0] code, input logic s, input logic [15:0] exp_s,
                      input logic [15:0] exp_u, input logic err);
    @(negedge clk);
    bus.valid    = 1'b1;
    bus.BCD_code = code;
    bus.sign     = s;
    push_exp(s, exp_s, exp_u, err, err ? 2 : 16);
    @(negedge clk);
    bus.valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    bus.valid    = 1'b0;
    bus.BCD_code = 16'h0000;
    bus.sign     = 1'b0;
    last.binary  = 16'h0000;
    last.error   = 1'b0;
    last.cyc     = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ready", 32'(bus.binary_ready), 32'd0);
    check("rst_binary", 32'(bus.binary), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);

    // code, sign, expected signed, expected unsigned, error
    send(16'h1234, 1'b0, 16'h04D2, 16'h04D2, 1'b0);
    send(16'h9999, 1'b1, 16'hD8F1, 16'h270F, 1'b0);
    send(16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0);
    send(16'h9999, 1'b0, 16'h270F, 16'h270F, 1'b0);
    send(16'h0010, 1'b1, 16'hFFF6, 16'h000A, 1'b0);
    send(16'h12A4, 1'b1, 16'h0000, 16'h0000, 1'b1);
    send(16'h0001, 1'b0, 16'h0001, 16'h0001, 1'b0);
    send(16'hF000, 1'b0, 16'h0000, 16'h0000, 1'b1);

    // valid pulsed while busy is ignored
    @(negedge clk);
    bus.valid = 1'b1; bus.BCD_code = 16'h0500; bus.sign = 1'b0;
    push_exp(1'b0, 16'h01F4, 16'h01F4, 1'b0, 16);
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_mid", 32'(bus.busy), 32'd1);
    bus.valid = 1'b1; bus.BCD_code = 16'h0007;
    @(negedge clk);
    bus.valid = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // valid held high: second request accepted right after the ready cycle
    @(negedge clk);
    bus.valid = 1'b1; bus.BCD_code = 16'h0255; bus.sign = 1'b0;
    push_exp(1'b0, 16'h00FF, 16'h00FF, 1'b0, 16);
    @(negedge clk);
    bus.BCD_code = 16'h8765; bus.sign = 1'b1;
    push_exp(1'b1, 16'hDDC3, 16'h223D, 1'b0, 31);
    repeat (16) @(negedge clk);
    bus.valid = 1'b0;
    wait_idle();

    // reset on the 5th shift edge aborts without a ready pulse
    @(negedge clk);
    bus.valid = 1'b1; bus.BCD_code = 16'h0500; bus.sign = 1'b0;
    @(negedge clk);
    bus.valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ready", 32'(bus.binary_ready), 32'd0);
    check("abort_binary", 32'(bus.binary), 32'd0);
    check("abort_error", 32'(bus.error), 32'd0);
    repeat (20) @(negedge clk);
    send(16'h0042, 1'b1, 16'hFFD6, 16'h002A, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
